// File: rtl/mips_mem_pkg.sv
// Shared opcodes, FSM encoding and access-classification helpers for the data-memory initiator.
// Pure declarations: no logic, no latency.
// No flow control of its own; consumers apply these to their own handshakes.
package mips_mem_pkg;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  localparam logic [5:0] MEM_OP_READ  = 6'b100011;
  localparam logic [5:0] MEM_OP_WRITE = 6'b101011;
  localparam logic [5:0] MEM_OP_NONE  = 6'b000000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Byte accesses are always aligned; unknown opcodes report aligned and are caught elsewhere.
  function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] addr);
    logic ok;
    case (op)
      LH, LHU, SH: ok = (addr[0] == 1'b0);
      LW, SW:      ok = (addr == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_mem_access_unit_if.sv
// Request/response and memory-bus bundle for the data-memory initiator.
// Wires only, no latency.
// Request side uses valid/ready; memory side uses single-cycle strobes.
interface mips_mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_load;
  logic        resp_err;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [5:0]  opcode;
  logic        signal_mem_read;
  logic        signal_mem_write;
  logic [31:0] read_data;

  // The access unit drives responses and the memory bus.
  modport master (
    input  req_valid, req_opcode, req_addr, req_wdata, read_data,
    output req_ready, resp_valid, resp_data, resp_load, resp_err,
    output address, data_in, opcode, signal_mem_read, signal_mem_write
  );

  // Pipeline stage plus memory: the other side of every signal.
  modport slave (
    output req_valid, req_opcode, req_addr, req_wdata, read_data,
    input  req_ready, resp_valid, resp_data, resp_load, resp_err,
    input  address, data_in, opcode, signal_mem_read, signal_mem_write
  );
endinterface

// File: rtl/mips_mem_lane_align.sv
// Big-endian lane selection: extended load value and merged sub-word store word.
// Purely combinational, zero latency.
// No handshake; the caller decides when the outputs are meaningful.
module mips_mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [5:0]  op,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword (byte 0 lives in bits 31:24) and extend per opcode.
  always_comb begin
    case (addr)
      2'b00:   byte_sel = word[31:24];
      2'b01:   byte_sel = word[23:16];
      2'b10:   byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr[1] ? word[15:0] : word[31:16];
    case (op)
      LB:      load_val = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_val = {24'd0, byte_sel};
      LH:      load_val = {{16{half_sel[15]}}, half_sel};
      LHU:     load_val = {16'd0, half_sel};
      default: load_val = word;
    endcase
  end

  // Replace only the addressed lane of the word read back for sb/sh.
  always_comb begin
    store_word = word;
    if (op == SB) begin
      case (addr)
        2'b00:   store_word[31:24] = wdata[7:0];
        2'b01:   store_word[23:16] = wdata[7:0];
        2'b10:   store_word[15:8]  = wdata[7:0];
        default: store_word[7:0]   = wdata[7:0];
      endcase
    end else if (op == SH) begin
      if (addr[1]) store_word[15:0]  = wdata[15:0];
      else         store_word[31:16] = wdata[15:0];
    end
  end

endmodule

// File: rtl/mips_mem_access_unit.sv
// Data-memory initiator: one load/store at a time, word accesses, sub-word extract and read-modify-write.
// Accept-to-response: error 1, sw 2, loads 2+READ_LATENCY, sb/sh 3+READ_LATENCY cycles.
// req_ready only in IDLE; no pipelining, the next request waits for the IDLE cycle after RESP.
module mips_mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_mem_access_unit_if.master bus
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY);

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] load_val;
  logic [31:0] store_word;
  logic        err;

  mips_mem_lane_align u_align (
    .word       (word_q),
    .addr       (addr_q[1:0]),
    .op         (op_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  // Unsupported opcodes and misaligned addresses never reach memory.
  assign err = !(is_load(op_q) || is_store(op_q)) || !is_aligned(op_q, addr_q[1:0]);

  // State, latched request, captured word and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 6'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and all outputs; memory bus fields are zero outside READ/WRITE.
  always_comb begin
    state_d              = state_q;
    op_d                 = op_q;
    addr_d               = addr_q;
    wdata_d              = wdata_q;
    word_d               = word_q;
    cnt_d                = cnt_q;
    bus.req_ready        = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.resp_data        = 32'd0;
    bus.resp_load        = 1'b0;
    bus.resp_err         = 1'b0;
    bus.address          = 32'd0;
    bus.data_in          = 32'd0;
    bus.opcode           = MEM_OP_NONE;
    bus.signal_mem_read  = 1'b0;
    bus.signal_mem_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d    = bus.req_opcode;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (!(is_load(bus.req_opcode) || is_store(bus.req_opcode)) ||
              !is_aligned(bus.req_opcode, bus.req_addr[1:0]))
            state_d = ST_RESP;
          else if (bus.req_opcode == SW)
            state_d = ST_WRITE;
          else
            state_d = ST_READ;
        end
      end
      ST_READ: begin
        bus.signal_mem_read = 1'b1;
        bus.address         = {addr_q[31:2], 2'b00};
        bus.opcode          = MEM_OP_READ;
        cnt_d               = LAT_INIT;
        state_d             = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          word_d  = bus.read_data;
          state_d = is_load(op_q) ? ST_RESP : ST_WRITE;
        end
      end
      ST_WRITE: begin
        bus.signal_mem_write = 1'b1;
        bus.address          = {addr_q[31:2], 2'b00};
        bus.opcode           = MEM_OP_WRITE;
        bus.data_in          = (op_q == SW) ? wdata_q : store_word;
        state_d              = ST_RESP;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err;
        bus.resp_load  = !err && is_load(op_q);
        bus.resp_data  = (!err && is_load(op_q)) ? load_val : 32'd0;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_mem_access_unit.sv
// Bench for the data-memory initiator: two instances (READ_LATENCY 1 and 3) with behavioural memories.
// Requests are scoreboarded; each response is compared against queued expectations.
// Strobe rules are watched continuously on both instances.
module tb_mips_mem_access_unit;
  import mips_mem_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        load;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wdat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic req_valid = 1'b0;
  logic [5:0] req_opcode = 6'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic pre_en = 1'b0;
  logic [31:0] pre_word = 32'd0;
  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  mips_mem_access_unit_if if1 ();
  mips_mem_access_unit_if if3 ();

  mips_mem_access_unit #(.READ_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
  mips_mem_access_unit #(.READ_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.master));

  always #5 clk = ~clk;

  assign if1.req_valid  = req_valid & ~sel;
  assign if3.req_valid  = req_valid & sel;
  assign if1.req_opcode = req_opcode;
  assign if3.req_opcode = req_opcode;
  assign if1.req_addr   = req_addr;
  assign if3.req_addr   = req_addr;
  assign if1.req_wdata  = req_wdata;
  assign if3.req_wdata  = req_wdata;

  // Observation of whichever instance is selected.
  logic        o_ready, o_rv, o_load, o_err, o_rd, o_wr;
  logic [31:0] o_data, o_addr, o_din;
  logic [5:0]  o_op;
  assign o_ready = sel ? if3.req_ready        : if1.req_ready;
  assign o_rv    = sel ? if3.resp_valid       : if1.resp_valid;
  assign o_load  = sel ? if3.resp_load        : if1.resp_load;
  assign o_err   = sel ? if3.resp_err         : if1.resp_err;
  assign o_rd    = sel ? if3.signal_mem_read  : if1.signal_mem_read;
  assign o_wr    = sel ? if3.signal_mem_write : if1.signal_mem_write;
  assign o_data  = sel ? if3.resp_data        : if1.resp_data;
  assign o_addr  = sel ? if3.address          : if1.address;
  assign o_din   = sel ? if3.data_in          : if1.data_in;
  assign o_op    = sel ? if3.opcode           : if1.opcode;

  // Behavioural memories: read data valid only in the cycle READ_LATENCY after the strobe.
  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];
  logic        v1_q = 1'b0;
  logic [3:0]  a1_q = 4'd0;
  logic [2:0]  v3_q = 3'd0;
  logic [3:0]  a3_q [3];
  always @(posedge clk) begin
    if (pre_en) begin
      mem1[4] <= pre_word;
      mem3[4] <= pre_word;
    end
    if (if1.signal_mem_write) mem1[if1.address[5:2]] <= if1.data_in;
    if (if3.signal_mem_write) mem3[if3.address[5:2]] <= if3.data_in;
    v1_q    <= if1.signal_mem_read;
    a1_q    <= if1.address[5:2];
    v3_q    <= {v3_q[1:0], if3.signal_mem_read};
    a3_q[0] <= if3.address[5:2];
    a3_q[1] <= a3_q[0];
    a3_q[2] <= a3_q[1];
  end
  assign if1.read_data = v1_q ? mem1[a1_q] : 32'hDEADBEEF;
  assign if3.read_data = v3_q[2] ? mem3[a3_q[2]] : 32'hDEADBEEF;

  // Strobes: one cycle at most, never read and write together.
  logic p_rd1 = 1'b0, p_wr1 = 1'b0, p_rd3 = 1'b0, p_wr3 = 1'b0;
  always @(negedge clk) begin
    if (if1.signal_mem_read || if1.signal_mem_write) begin
      checks++;
      if ((if1.signal_mem_read && (if1.signal_mem_write || p_rd1)) || (if1.signal_mem_write && p_wr1)) begin
        errors++;
        $display("FAIL strobe_rule_dut1 rd=%b wr=%b prev_rd=%b prev_wr=%b want single one-cycle strobe",
                 if1.signal_mem_read, if1.signal_mem_write, p_rd1, p_wr1);
      end
    end
    if (if3.signal_mem_read || if3.signal_mem_write) begin
      checks++;
      if ((if3.signal_mem_read && (if3.signal_mem_write || p_rd3)) || (if3.signal_mem_write && p_wr3)) begin
        errors++;
        $display("FAIL strobe_rule_dut3 rd=%b wr=%b prev_rd=%b prev_wr=%b want single one-cycle strobe",
                 if3.signal_mem_read, if3.signal_mem_write, p_rd3, p_wr3);
      end
    end
    p_rd1 = if1.signal_mem_read;
    p_wr1 = if1.signal_mem_write;
    p_rd3 = if3.signal_mem_read;
    p_wr3 = if3.signal_mem_write;
  end

  task automatic preload(input logic [31:0] w);
    @(negedge clk);
    pre_word = w;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  // Issue one request, watch the memory bus until the response, then compare against the scoreboard.
  task automatic do_req(input logic s, input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] x_data, input logic x_load, input logic x_err, input int x_lat,
                        input int x_rd, input int x_wr, input logic [31:0] x_wdat, input string nm);
    exp_t e;
    int rd_n = 0, wr_n = 0, g_lat = 0;
    logic got = 1'b0;
    logic g_load = 1'b0, g_err = 1'b0;
    logic [31:0] g_data = 32'd0, g_wdat = 32'd0;
    e.data = x_data; e.load = x_load; e.err = x_err; e.lat = x_lat;
    e.rd = x_rd; e.wr = x_wr; e.wdat = x_wdat;
    sb_q.push_back(e);
    @(negedge clk);
    sel = s;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL %s_ready_idle got %b want 1", nm, o_ready);
    end
    req_valid = 1'b1; req_opcode = op; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_opcode = 6'h3F; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_rd) begin
        rd_n++;
        checks++;
        if (o_addr !== {a[31:2], 2'b00} || o_op !== MEM_OP_READ) begin
          errors++; $display("FAIL %s_read_bus addr %h op %b want %h %b", nm, o_addr, o_op, {a[31:2], 2'b00}, MEM_OP_READ);
        end
      end
      if (o_wr) begin
        wr_n++;
        g_wdat = o_din;
        checks++;
        if (o_addr !== {a[31:2], 2'b00} || o_op !== MEM_OP_WRITE) begin
          errors++; $display("FAIL %s_write_bus addr %h op %b want %h %b", nm, o_addr, o_op, {a[31:2], 2'b00}, MEM_OP_WRITE);
        end
      end
      if (o_rv) begin
        got = 1'b1; g_lat = k; g_data = o_data; g_load = o_load; g_err = o_err;
        checks++;
        if (o_ready !== 1'b0) begin
          errors++; $display("FAIL %s_ready_in_resp got %b want 0", nm, o_ready);
        end
        break;
      end
    end
    e = sb_q.pop_front();
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s_timeout got no resp_valid want one within 40 cycles", nm);
    end else begin
      if (g_lat != e.lat) begin errors++; $display("FAIL %s_latency got %0d want %0d", nm, g_lat, e.lat); end
      checks++;
      if (g_data !== e.data) begin errors++; $display("FAIL %s_resp_data got %h want %h", nm, g_data, e.data); end
      checks++;
      if (g_load !== e.load || g_err !== e.err) begin
        errors++; $display("FAIL %s_flags got load=%b err=%b want load=%b err=%b", nm, g_load, g_err, e.load, e.err);
      end
    end
    checks++;
    if (rd_n != e.rd || wr_n != e.wr) begin
      errors++; $display("FAIL %s_strobe_count got rd=%0d wr=%0d want rd=%0d wr=%0d", nm, rd_n, wr_n, e.rd, e.wr);
    end
    if (e.wr > 0) begin
      checks++;
      if (g_wdat !== e.wdat) begin errors++; $display("FAIL %s_write_data got %h want %h", nm, g_wdat, e.wdat); end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (if1.req_ready !== 1'b1 || if1.resp_valid !== 1'b0 || if1.resp_data !== 32'd0 ||
        if1.resp_load !== 1'b0 || if1.resp_err !== 1'b0 || if1.address !== 32'd0 ||
        if1.data_in !== 32'd0 || if1.opcode !== 6'd0 || if1.signal_mem_read !== 1'b0 ||
        if1.signal_mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b rv=%b data=%h addr=%h din=%h op=%b rd=%b wr=%b want ready=1 rest 0",
               if1.req_ready, if1.resp_valid, if1.resp_data, if1.address, if1.data_in, if1.opcode,
               if1.signal_mem_read, if1.signal_mem_write);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    preload(32'h8899AABB);
    do_req(1'b0, LB,  32'h11, 32'd0, 32'hFFFFFF99, 1'b1, 1'b0, 3, 1, 0, 32'd0, "lb_11");
    do_req(1'b0, LBU, 32'h13, 32'd0, 32'h000000BB, 1'b1, 1'b0, 3, 1, 0, 32'd0, "lbu_13");
    do_req(1'b0, LH,  32'h12, 32'd0, 32'hFFFFAABB, 1'b1, 1'b0, 3, 1, 0, 32'd0, "lh_12");
    do_req(1'b0, LHU, 32'h10, 32'd0, 32'h00008899, 1'b1, 1'b0, 3, 1, 0, 32'd0, "lhu_10");
    do_req(1'b0, LW,  32'h10, 32'd0, 32'h8899AABB, 1'b1, 1'b0, 3, 1, 0, 32'd0, "lw_10");
  endtask

  task automatic test_stores();
    do_req(1'b0, SH, 32'h12, 32'h12345678, 32'd0, 1'b0, 1'b0, 4, 1, 1, 32'h88995678, "sh_12");
    do_req(1'b0, LW, 32'h10, 32'd0, 32'h88995678, 1'b1, 1'b0, 3, 1, 0, 32'd0, "lw_after_sh");
    preload(32'h8899AABB);
    do_req(1'b0, SB, 32'h10, 32'h000000EE, 32'd0, 1'b0, 1'b0, 4, 1, 1, 32'hEE99AABB, "sb_10");
    preload(32'h8899AABB);
    do_req(1'b0, SW, 32'h10, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0, 2, 0, 1, 32'hCAFEF00D, "sw_10");
    do_req(1'b0, LW, 32'h10, 32'd0, 32'hCAFEF00D, 1'b1, 1'b0, 3, 1, 0, 32'd0, "lw_after_sw");
  endtask

  task automatic test_errors();
    do_req(1'b0, LW,        32'h12, 32'd0, 32'd0, 1'b0, 1'b1, 1, 0, 0, 32'd0, "err_lw_12");
    do_req(1'b0, 6'b000100, 32'h10, 32'd0, 32'd0, 1'b0, 1'b1, 1, 0, 0, 32'd0, "err_opcode");
    do_req(1'b0, LH,        32'h11, 32'd0, 32'd0, 1'b0, 1'b1, 1, 0, 0, 32'd0, "err_lh_11");
    do_req(1'b0, SH,        32'h13, 32'h1, 32'd0, 1'b0, 1'b1, 1, 0, 0, 32'd0, "err_sh_13");
  endtask

  task automatic test_latency3();
    preload(32'h8899AABB);
    do_req(1'b1, LW, 32'h10, 32'd0, 32'h8899AABB, 1'b1, 1'b0, 5, 1, 0, 32'd0, "lw_lat3");
    do_req(1'b1, SB, 32'h13, 32'h000000EE, 32'd0, 1'b0, 1'b0, 6, 1, 1, 32'h8899AAEE, "sb_lat3");
    do_req(1'b0, LB, 32'h12, 32'd0, 32'hFFFFFFAA, 1'b1, 1'b0, 3, 1, 0, 32'd0, "lb_lat1_after");
  endtask

  task automatic test_reset_mid();
    preload(32'h8899AABB);
    @(negedge clk);
    sel = 1'b0;
    req_valid = 1'b1; req_opcode = SB; req_addr = 32'h10; req_wdata = 32'h000000EE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (if1.signal_mem_read !== 1'b0 || if1.signal_mem_write !== 1'b0 || if1.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_async got rd=%b wr=%b ready=%b want 0 0 1",
                         if1.signal_mem_read, if1.signal_mem_write, if1.req_ready);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      checks++;
      if (if1.signal_mem_write !== 1'b0 || if1.resp_valid !== 1'b0) begin
        errors++; $display("FAIL reset_mid_quiet cycle %0d got wr=%b rv=%b want 0 0", k, if1.signal_mem_write, if1.resp_valid);
      end
    end
    do_req(1'b0, LW, 32'h10, 32'd0, 32'h8899AABB, 1'b1, 1'b0, 3, 1, 0, 32'd0, "lw_after_abort");
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_latency3();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mem_access_unit.md
Name: mips_mem_access_unit

Overview:
- Initiator side of the data-memory interface. Sits between the MEM pipeline stage and mips_data_memory.
- Accepts one load/store request at a time and issues word-aligned word reads/writes to memory.
- Performs sub-word extraction with sign/zero extension for loads, and read-modify-write for sb/sh.
- Flags misaligned and unsupported accesses without touching memory.

Parameters:
- READ_LATENCY, 1, cycles from the cycle signal_mem_read is asserted to the cycle mem_read_data is valid (legal range 1..7).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted on req_valid && req_ready at a rising edge.
- req_opcode  in  6  MIPS opcode: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; sub-word stores use the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  extended load result; 0 for stores and errors.
- resp_load  out  1  with resp_valid: successful load (register write-back enable).
- resp_err  out  1  with resp_valid: misaligned or unsupported opcode.
- address  out  32  to memory: {req_addr[31:2],2'b00}.
- data_in  out  32  to memory: write word.
- opcode  out  6  to memory: 100011 on reads, 101011 on writes, 000000 otherwise.
- signal_mem_read  out  1  one-cycle read strobe.
- signal_mem_write  out  1  one-cycle write strobe; memory writes at the end of that cycle.
- read_data  in  32  word from memory.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, req_ready=1.
  - All other outputs 0: resp_*, address, data_in, opcode, signal_mem_read, signal_mem_write.
  - Latched request cleared.
- Request handling:
  - Request fields are latched at acceptance; inputs are don't-care afterwards.
  - req_ready=1 only in IDLE. No pipelining.
- Byte order is big-endian:
  - addr[1:0]=00 → bits 31:24; 01 → 23:16; 10 → 15:8; 11 → 7:0.
  - Halfword addr[1]=0 → 31:16; addr[1]=1 → 15:0.
- Alignment:
  - lh/lhu/sh require addr[0]=0.
  - lw/sw require addr[1:0]=00.
  - b-type accesses are always aligned.
- FSM states: IDLE, READ, WAIT, WRITE, RESP.
- IDLE on accept:
  - misaligned or unknown opcode → RESP with error.
  - sw → WRITE.
  - all others → READ.
- READ:
  - signal_mem_read=1 for exactly one cycle; latency counter loaded with READ_LATENCY → WAIT.
- WAIT:
  - counter decrements; memory outputs idle.
  - In the cycle the counter reaches 1, capture read_data.
  - Loads → RESP.
  - sb/sh → WRITE with the merged word: the read word with the addressed lane replaced by req_wdata[7:0] or req_wdata[15:0].
- WRITE:
  - signal_mem_write=1 one cycle; data_in = req_wdata (sw) or merged word → RESP.
- RESP:
  - resp_valid=1 one cycle → IDLE.
  - resp_err=1 for errors; resp_load=1 for successful loads.
- Load extraction:
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Latency, accept edge to resp_valid cycle, with READ_LATENCY=L:
  - error 1 cycle.
  - sw 2 cycles.
  - loads 2+L cycles.
  - sb/sh 3+L cycles.
- address/opcode are driven only in READ and WRITE cycles; data_in only in WRITE. All are 0 otherwise.
- A single strobe is never asserted for more than one cycle; read and write are never asserted together.
- Reset mid-operation:
  - Immediate abort; strobes drop asynchronously; no response.
  - If reset arrives in READ/WAIT of sb/sh, memory is never written.
- resp_valid and req_ready are never both 1. A new request can be accepted on the edge ending RESP+1 (IDLE cycle).

Decomposition:
- Package mips_mem_pkg:
  - opcode constants (LB…SW, MEM_OP_READ=100011, MEM_OP_WRITE=101011).
  - FSM state encoding (3-bit).
  - function is_load/is_store/is_aligned.
- Sub-module mips_mem_lane_align (combinational):
  - inputs: word, addr[1:0], opcode, wdata.
  - outputs: extended load value, merged store word.
- The FSM, latency counter and request latch stay in the top module.

Test Plan:
- Memory word @0x10=0x8899AABB, L=1:
  - lb 0x11 → resp_data 0xFFFFFF99, resp_load=1, resp_valid 3 cycles after accept.
  - lbu 0x13 → 0x000000BB.
  - lh 0x12 → 0xFFFFAABB.
  - lhu 0x10 → 0x00008899.
- sh 0x12, wdata 0x12345678:
  - one read of 0x10, then one write of data_in=0x88995678, opcode 101011.
  - resp_valid 4 cycles after accept, resp_load=0.
- sb 0x10, wdata 0x000000EE → write 0xEE99AABB.
- sw 0x10, wdata 0xCAFEF00D → signal_mem_write in the cycle after accept, no read, resp 2 cycles after accept.
- lw 0x12 → resp_err=1 in the cycle after accept, resp_data=0, signal_mem_read/write never asserted.
- Opcode 000100 → same error response.
- READ_LATENCY=3, lw 0x10 → read strobe once, capture 3 cycles later, resp_valid 5 cycles after accept with 0x8899AABB.
- rst_n low during WAIT of sb → no write strobe ever, no resp_valid, req_ready=1 after release, next lw 0x10 still returns the old word.
